// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO burst arbiter.
// Holds the FSM state enum, the counter width and the clog2-based width helpers.
// No ports; imported by the interface, the picker and the arbiter top.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam int WR_COUNT_W = 16;

   // Width of a requester index; never below one bit.
   function automatic int id_w(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   // Width of the beat counter, which must be able to hold MAX_BURST itself.
   function automatic int beat_w(input int max_burst);
      return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
   endfunction

endpackage

// File: rtl/fifo_burst_arbiter_if.sv
// Bundle of requester streams, FIFO write port and grant status for the arbiter.
// Ports: req_valid/req_last/req_data in, req_ready out, fifo_full in, fifo_wr_en/fifo_wr_data out,
//        grant_valid/grant_id/wr_count out. slave = arbiter side, master = producer/FIFO side.
interface fifo_burst_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int NREQ   = 2
);
   localparam int ID_W = fifo_arb_pkg::id_w(NREQ);

   logic [NREQ-1:0]                     req_valid;
   logic [NREQ-1:0]                     req_last;
   logic [NREQ*DATA_W-1:0]              req_data;
   logic [NREQ-1:0]                     req_ready;
   logic                                fifo_full;
   logic                                fifo_wr_en;
   logic [DATA_W-1:0]                   fifo_wr_data;
   logic                                grant_valid;
   logic [ID_W-1:0]                     grant_id;
   logic [fifo_arb_pkg::WR_COUNT_W-1:0] wr_count;

   modport slave (
      input  req_valid, req_last, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id, wr_count
   );

   modport master (
      output req_valid, req_last, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id, wr_count
   );

endinterface

// File: rtl/fifo_burst_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NREQ.
// Ports: req_i (request vector), ptr_i (search start) -> found_o (any request), idx_o (winner).
// Purely combinational, no state, no backpressure.
module rr_pick #(
   parameter int NREQ  = 2,
   parameter int IDX_W = 1
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   int cand;

   // Walk offsets from farthest to nearest so the nearest hit to ptr_i is the last write.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = 0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         cand = int'(ptr_i) + off;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (req_i[cand[IDX_W-1:0]]) begin
            found_o = 1'b1;
            idx_o   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NREQ valid/ready producers.
// Ports: clk, rst_n (async active-low), bus (slave modport: streams, FIFO write port, grant status).
// One IDLE grant cycle per burst, then 1 beat/cycle; fifo_full stalls the owner combinationally.
module fifo_burst_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NREQ      = 2,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   fifo_burst_arbiter_if.slave bus
);

   localparam int                ID_W      = id_w(NREQ);
   localparam int                BEAT_W    = beat_w(MAX_BURST);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
   localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NREQ - 1);

   state_t                  state_q, state_d;
   logic [ID_W-1:0]         owner_q, owner_d;
   logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic [WR_COUNT_W-1:0]   wr_count_q, wr_count_d;

   logic                    pick_found;
   logic [ID_W-1:0]         pick_idx;
   logic [NREQ-1:0]         ready;
   logic                    wr_en;
   logic                    xfer;
   logic                    owner_vld;
   logic                    owner_last;
   logic [DATA_W-1:0]       owner_data;

   rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (ID_W)
   ) u_pick (
      .req_i   (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign owner_vld  = bus.req_valid[owner_q];
   assign owner_last = bus.req_last[owner_q];
   assign owner_data = bus.req_data[int'(owner_q)*DATA_W +: DATA_W];

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      wr_count_d = wr_count_q;
      ready      = '0;
      wr_en      = 1'b0;
      xfer       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               owner_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            ready[owner_q] = !bus.fifo_full;
            xfer           = owner_vld && !bus.fifo_full;
            if (xfer) begin
               wr_en      = 1'b1;
               beat_cnt_d = beat_cnt_q + 1'b1;
               wr_count_d = wr_count_q + 1'b1;
            end
            // Full only stalls; the burst ends on last, on the final allowed beat,
            // or when the owner stops presenting data.
            if ((xfer && (owner_last || (beat_cnt_q == LAST_BEAT))) || !owner_vld) begin
               state_d  = IDLE;
               rr_ptr_d = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign bus.req_ready    = ready;
   assign bus.fifo_wr_en   = wr_en;
   assign bus.fifo_wr_data = owner_data;
   assign bus.grant_valid  = (state_q == BURST);
   assign bus.grant_id     = owner_q;
   assign bus.wr_count     = wr_count_q;

endmodule
